sobel3x3_stream: RTL and testbench

- Streaming 3x3 Sobel gradient-magnitude stage placed directly downstream of the 5x5 Gaussian smoothing filter.
- Consumes one smoothed 16-bit pixel per valid cycle in raster order (row-major, M pixels per row, N rows per frame).
- Keeps two line buffers and a 3x3 window, and emits |Gx|+|Gy| for every interior pixel.
- No full-frame storage. Frame boundaries are derived purely by counting.

---
 rtl/sobel3x3_stream_if.sv | 21 ++
 rtl/sobel3x3_stream.sv | 151 +++++++++++++++
 tb/tb_sobel3x3_stream.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel3x3_stream_if.sv
// Pixel stream bundle between the smoothing stage, the Sobel stage and its consumer.
interface sobel3x3_stream_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] Din;
  logic          data_valid;
  logic [DW-1:0] Dout;
  logic          dout_valid;
  logic          frame_done;
  logic          busy;

  modport master (
    output Din, data_valid,
    input  Dout, dout_valid, frame_done, busy
  );

  modport slave (
    input  Din, data_valid,
    output Dout, dout_valid, frame_done, busy
  );
endinterface

// File: rtl/sobel3x3_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| over a raster pixel stream using two line buffers;
// frame position is tracked purely by counting accepted pixels.
module sobel3x3_stream #(
  parameter int unsigned N  = 480,
  parameter int unsigned M  = 320,
  parameter int unsigned DW = 16
) (
  input logic               clk,
  input logic               rst,
  sobel3x3_stream_if.slave  io
);
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 8;
  localparam int unsigned SW = 10;
  localparam int unsigned MW = 11;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e                     state_q, state_d;
  logic                       pend_q, pend_d;
  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic [2:0][2:0][PW-1:0]    win_q, win_d;
  logic                       win_vld_q, win_vld_d;
  logic [DW-1:0]              dout_q, dout_d;
  logic                       dout_vld_q, dout_vld_d;
  logic                       frame_done_q, frame_done_d;
  logic                       busy_q, busy_d;

  logic [PW-1:0]              lb0_mem [M];
  logic [PW-1:0]              lb1_mem [M];

  logic [PW-1:0]              px_c, lb0_rd_c, lb1_rd_c;
  logic                       last_col_c, last_px_c;
  logic [SW-1:0]              gx_pos_c, gx_neg_c, gy_pos_c, gy_neg_c, ax_c, ay_c;
  logic [MW-1:0]              mag_c;

  // Saturate the smoothed input to 8 bits and fetch the two rows above
  always_comb begin
    px_c       = (io.Din > DW'(255)) ? PW'(255) : io.Din[PW-1:0];
    lb0_rd_c   = lb0_mem[col_q];
    lb1_rd_c   = lb1_mem[col_q];
    last_col_c = (col_q == CW'(M - 1));
    last_px_c  = last_col_c && (row_q == RW'(N - 1));
  end

  // Gradient magnitude of the registered window; differences taken unsigned to avoid sign handling
  always_comb begin
    gx_pos_c = SW'(win_q[0][2]) + (SW'(win_q[1][2]) << 1) + SW'(win_q[2][2]);
    gx_neg_c = SW'(win_q[0][0]) + (SW'(win_q[1][0]) << 1) + SW'(win_q[2][0]);
    gy_pos_c = SW'(win_q[2][0]) + (SW'(win_q[2][1]) << 1) + SW'(win_q[2][2]);
    gy_neg_c = SW'(win_q[0][0]) + (SW'(win_q[0][1]) << 1) + SW'(win_q[0][2]);
    ax_c     = (gx_pos_c >= gx_neg_c) ? (gx_pos_c - gx_neg_c) : (gx_neg_c - gx_pos_c);
    ay_c     = (gy_pos_c >= gy_neg_c) ? (gy_pos_c - gy_neg_c) : (gy_neg_c - gy_pos_c);
    mag_c    = MW'(ax_c) + MW'(ay_c);
  end

  // Next-state: counters, window, output stage and frame FSM
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_vld_d    = 1'b0;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = 1'b0;

    if (io.data_valid) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_rd_c;
      win_d[1][2] = lb1_rd_c;
      win_d[2][2] = px_c;
      win_vld_d   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    end

    if (win_vld_q) begin
      dout_d     = DW'(mag_c);
      dout_vld_d = 1'b1;
    end

    case (state_q)
      IDLE:  if (io.data_valid) state_d = RUN;
      RUN:   if (io.data_valid && last_px_c) state_d = FLUSH;
      FLUSH: begin
        state_d = DONE;
        pend_d  = io.data_valid;
      end
      DONE: begin
        state_d = (io.data_valid || pend_q) ? RUN : IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // frame_done follows the last result by a cycle; busy drops on the same edge
    frame_done_d = (state_q == DONE);
    busy_d       = (state_d == RUN) || (state_d == FLUSH) || (state_q == FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_vld_q    <= 1'b0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_vld_q    <= win_vld_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Line buffers are never cleared; stale rows are masked by the row count
  always_ff @(posedge clk) begin
    if (io.data_valid) begin
      lb0_mem[col_q] <= lb1_rd_c;
      lb1_mem[col_q] <= px_c;
    end
  end

  assign io.Dout       = dout_q;
  assign io.dout_valid = dout_vld_q;
  assign io.frame_done = frame_done_q;
  assign io.busy       = busy_q;
endmodule

// File: tb/tb_sobel3x3_stream.sv
// Self-checking bench for sobel3x3_stream on a 4x5 frame against a 2-D array Sobel model.
module tb_sobel3x3_stream;
  localparam int TN = 4;
  localparam int TM = 5;
  localparam int TP = TN * TM;

  logic clk;
  logic rst;
  sobel3x3_stream_if #(.DW(16)) bus ();

  sobel3x3_stream #(.N(TN), .M(TM), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] stim [$];
  int          acc [$];
  int          oval [$];
  int          ocyc [$];
  int          fd_cyc [$];
  int          rise_cyc [$];
  int          fall_cyc [$];
  logic        busy_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every observable event with the number of rising edges seen so far
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      oval.push_back(int'(bus.Dout));
      ocyc.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (bus.busy === 1'b1 && busy_prev === 1'b0) rise_cyc.push_back(cyc);
    if (bus.busy === 1'b0 && busy_prev === 1'b1) fall_cyc.push_back(cyc);
    busy_prev = bus.busy;
  end

  function automatic void sobel_model(input logic [15:0] f [$], input int base, output int ev [$]);
    int p [TN][TM];
    int gx, gy;
    ev.delete();
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TM; c++)
        p[r][c] = (f[base + r*TM + c] > 16'd255) ? 255 : int'(f[base + r*TM + c][7:0]);
    for (int r = 1; r < TN - 1; r++)
      for (int c = 1; c < TM - 1; c++) begin
        gx = (p[r-1][c+1] + 2*p[r][c+1] + p[r+1][c+1]) - (p[r-1][c-1] + 2*p[r][c-1] + p[r+1][c-1]);
        gy = (p[r+1][c-1] + 2*p[r+1][c] + p[r+1][c+1]) - (p[r-1][c-1] + 2*p[r-1][c] + p[r-1][c+1]);
        ev.push_back((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy));
      end
  endfunction

  function automatic void exp_cycles(input int a [$], input int base, output int ec [$]);
    ec.delete();
    for (int k = 0; k < TP; k++)
      if (k / TM >= 2 && k % TM >= 2) ec.push_back(a[base + k] + 1);
  endfunction

  task automatic clear_mon();
    oval.delete(); ocyc.delete(); fd_cyc.delete(); rise_cyc.delete(); fall_cyc.delete();
  endtask

  task automatic drive_frame(input int gap_pct);
    acc.delete();
    foreach (stim[k]) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.data_valid = 1'b0;
        bus.Din        = 16'($urandom);
        @(negedge clk);
      end
      bus.data_valid = 1'b1;
      bus.Din        = stim[k];
      acc.push_back(cyc + 1);
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    bus.Din        = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.data_valid = 1'b0;
    bus.Din = 16'hFFFF;
    repeat (3) @(negedge clk);
    checks++; if (bus.Dout !== 16'd0) begin errors++; $display("FAIL reset_dout got %0d want 0", bus.Dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b want 0", bus.dout_valid); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL idle_quiet got busy=%b dv=%b want 0 0", bus.busy, bus.dout_valid); end
  endtask

  task automatic test_constant();
    int ev [$]; int ec [$];
    stim.delete();
    for (int k = 0; k < TP; k++) stim.push_back(16'd100);
    clear_mon();
    drive_frame(0);
    repeat (8) @(negedge clk);
    sobel_model(stim, 0, ev);
    exp_cycles(acc, 0, ec);
    checks++; if (oval.size() !== 6) begin errors++; $display("FAIL const_count got %0d want 6", oval.size()); end
    for (int i = 0; i < ev.size() && i < oval.size(); i++) begin
      checks++; if (oval[i] !== ev[i]) begin errors++; $display("FAIL const_val[%0d] got %0d want %0d", i, oval[i], ev[i]); end
      checks++; if (ocyc[i] !== ec[i]) begin errors++; $display("FAIL const_lat[%0d] got cyc %0d want %0d", i, ocyc[i], ec[i]); end
    end
    checks++; if (fd_cyc.size() !== 1 || (fd_cyc.size() > 0 && fd_cyc[0] !== acc[TP-1] + 2)) begin
      errors++; $display("FAIL const_frame_done got %0d pulses first at %0d want 1 at %0d", fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1, acc[TP-1] + 2); end
    checks++; if (rise_cyc.size() !== 1 || (rise_cyc.size() > 0 && rise_cyc[0] !== acc[0])) begin
      errors++; $display("FAIL const_busy_rise got %0d want %0d", rise_cyc.size() > 0 ? rise_cyc[0] : -1, acc[0]); end
    checks++; if (fall_cyc.size() !== 1 || (fall_cyc.size() > 0 && fall_cyc[0] !== acc[TP-1] + 2)) begin
      errors++; $display("FAIL const_busy_fall got %0d want %0d", fall_cyc.size() > 0 ? fall_cyc[0] : -1, acc[TP-1] + 2); end
  endtask

  task automatic run_pattern(input string name, input int gap_pct);
    int ev [$]; int ec [$];
    clear_mon();
    drive_frame(gap_pct);
    repeat (8) @(negedge clk);
    sobel_model(stim, 0, ev);
    exp_cycles(acc, 0, ec);
    checks++; if (oval.size() !== ev.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", name, oval.size(), ev.size()); end
    for (int i = 0; i < ev.size() && i < oval.size(); i++) begin
      checks++; if (oval[i] !== ev[i]) begin errors++; $display("FAIL %s_val[%0d] got %0d want %0d", name, i, oval[i], ev[i]); end
      checks++; if (ocyc[i] !== ec[i]) begin errors++; $display("FAIL %s_lat[%0d] got cyc %0d want %0d", name, i, ocyc[i], ec[i]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL %s_frame_done got %0d pulses want 1", name, fd_cyc.size()); end
  endtask

  task automatic test_ramp();
    stim.delete();
    for (int k = 0; k < TP; k++) stim.push_back(16'(10 * (k % TM)));
    run_pattern("ramp", 0);
    checks++; if (oval.size() < 1 || oval[0] !== 80) begin errors++; $display("FAIL ramp_first got %0d want 80", oval.size() > 0 ? oval[0] : -1); end
  endtask

  task automatic test_bright();
    stim.delete();
    for (int k = 0; k < TP; k++) stim.push_back((k == TM + 1) ? 16'd255 : 16'd0);
    run_pattern("bright", 0);
    checks++; if (oval.size() < 2 || oval[0] !== 0 || oval[1] !== 510) begin
      errors++; $display("FAIL bright_centre got %0d,%0d want 0,510", oval.size() > 0 ? oval[0] : -1, oval.size() > 1 ? oval[1] : -1); end
  endtask

  task automatic test_saturate();
    stim.delete();
    for (int k = 0; k < TP; k++) stim.push_back((k % TM == 0) ? 16'h0300 : 16'd0);
    run_pattern("sat", 0);
    checks++; if (oval.size() < 4 || oval[0] !== 1020 || oval[3] !== 1020) begin
      errors++; $display("FAIL sat_row_start got %0d,%0d want 1020,1020", oval.size() > 0 ? oval[0] : -1, oval.size() > 3 ? oval[3] : -1); end
  endtask

  task automatic test_gaps();
    stim.delete();
    for (int k = 0; k < TP; k++) stim.push_back(16'(10 * (k % TM)));
    run_pattern("gaps", 50);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      stim.delete();
      for (int k = 0; k < TP; k++) stim.push_back(16'($urandom_range(0, 600)));
      run_pattern("rand", 30);
    end
  endtask

  task automatic test_back_to_back();
    int ev [$]; int ev2 [$]; int ec [$]; int ec2 [$];
    stim.delete();
    for (int k = 0; k < 2*TP; k++) stim.push_back(16'($urandom_range(0, 400)));
    clear_mon();
    drive_frame(0);
    repeat (8) @(negedge clk);
    sobel_model(stim, 0, ev);  sobel_model(stim, TP, ev2);
    exp_cycles(acc, 0, ec);    exp_cycles(acc, TP, ec2);
    ev = {ev, ev2};
    ec = {ec, ec2};
    checks++; if (oval.size() !== ev.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", oval.size(), ev.size()); end
    for (int i = 0; i < ev.size() && i < oval.size(); i++) begin
      checks++; if (oval[i] !== ev[i]) begin errors++; $display("FAIL b2b_val[%0d] got %0d want %0d", i, oval[i], ev[i]); end
      checks++; if (ocyc[i] !== ec[i]) begin errors++; $display("FAIL b2b_lat[%0d] got cyc %0d want %0d", i, ocyc[i], ec[i]); end
    end
    checks++; if (fd_cyc.size() !== 2 || (fd_cyc.size() == 2 && (fd_cyc[0] !== acc[TP-1] + 2 || fd_cyc[1] !== acc[2*TP-1] + 2))) begin
      errors++; $display("FAIL b2b_frame_done got %0d pulses want 2 at %0d,%0d", fd_cyc.size(), acc[TP-1] + 2, acc[2*TP-1] + 2); end
  endtask

  task automatic test_reset_mid();
    int ec [$];
    stim.delete();
    for (int k = 0; k < 12; k++) stim.push_back(16'($urandom_range(0, 255)));
    clear_mon();
    drive_frame(0);
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_async_busy got %b want 0", bus.busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stim.delete();
    for (int k = 0; k < TP; k++) stim.push_back(16'(10 * (k % TM)));
    drive_frame(0);
    repeat (8) @(negedge clk);
    exp_cycles(acc, 0, ec);
    checks++; if (oval.size() !== 6) begin errors++; $display("FAIL rstmid_count got %0d want 6", oval.size()); end
    for (int i = 0; i < oval.size() && i < ec.size(); i++) begin
      checks++; if (oval[i] !== 80) begin errors++; $display("FAIL rstmid_val[%0d] got %0d want 80", i, oval[i]); end
    end
    checks++; if (ocyc.size() < 1 || ocyc[0] !== acc[2*TM + 2] + 1) begin
      errors++; $display("FAIL rstmid_first got cyc %0d want %0d", ocyc.size() > 0 ? ocyc[0] : -1, acc[2*TM + 2] + 1); end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL rstmid_frame_done got %0d pulses want 1", fd_cyc.size()); end
  endtask

  initial begin
    rst = 1'b0;
    bus.data_valid = 1'b0;
    bus.Din = 16'd0;
    test_reset();
    test_constant();
    test_ramp();
    test_bright();
    test_saturate();
    test_gaps();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish before 200000ns");
    $fatal(1, "timeout");
  end
endmodule
